// File: rtl/shiftreg165_scan_if.sv
// shiftreg165_scan_if: chain pins and frame outputs shared between the 74HC165 scanner and its consumers.
interface shiftreg165_scan_if #(parameter int WIDTH = 8);
  logic clk_en, q, freeze, cp, pl, sync, changed;
  logic [WIDTH-1:0] d_raw, d;
  modport master(input clk_en, q, freeze, output cp, pl, d_raw, d, sync, changed);
  modport slave(output clk_en, q, freeze, input cp, pl, d_raw, d, sync, changed);
endinterface

// File: rtl/shiftreg165_scan.sv
// shiftreg165_scan: scans a 74HC165 chain into frames, then debounces them, flags changes and supports freezing the output.
module shiftreg165_scan #(
  parameter int   WIDTH         = 8,
  parameter logic DEFAULT_STATE = 1'b1,
  parameter int   FILTER        = 2,
  parameter int   PL_CYCLES     = 1
) (
  input logic                clk28,
  input logic                rst_n,
  shiftreg165_scan_if.master bus
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] DEF = {WIDTH{DEFAULT_STATE}};
  localparam logic [1:0] M_MAX = 2'(FILTER - 1);
  localparam logic [1:0] T_LOAD = 2'(PL_CYCLES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);
  typedef enum logic [1:0] {LOAD, SHIFT, COMMIT} state_t;
  state_t r_state, w_state;
  logic [1:0] r_tick, w_tick, r_match, w_match;
  logic [BW-1:0] r_bit, w_bit;
  logic [WIDTH-1:0] r_sr, r_d_raw, r_d, r_cand;
  logic r_sync, r_changed, w_commit, w_shift, w_take;
  always_comb begin
    w_state = r_state;
    w_tick = r_tick;
    w_bit = r_bit;
    if (bus.clk_en && r_state == LOAD) begin
      w_tick = r_tick == T_LOAD ? 2'd0 : r_tick + 2'd1;
      w_bit = '0;
      w_state = r_tick == T_LOAD ? SHIFT : LOAD;
    end else if (bus.clk_en && r_state == SHIFT) begin
      w_tick = {1'b0, ~r_tick[0]};
      w_bit = r_tick[0] ? r_bit + BW'(1) : r_bit;
      w_state = r_tick[0] && r_bit == B_LAST ? COMMIT : SHIFT;
    end else if (bus.clk_en && r_state == COMMIT) begin
      w_tick = 2'd0;
      w_state = LOAD;
    end
  end
  // A frame differing from the candidate restarts the run; identical frames count up to the threshold.
  assign w_match = r_sr != r_cand ? 2'd0 : r_match == M_MAX ? M_MAX : r_match + 2'd1;
  assign w_take = w_match == M_MAX && !bus.freeze;
  assign w_commit = bus.clk_en && r_state == COMMIT;
  assign w_shift = bus.clk_en && r_state == SHIFT && !r_tick[0];
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
      r_tick <= '0;
      r_bit <= '0;
      r_sr <= DEF;
      r_d_raw <= DEF;
      r_d <= DEF;
      r_cand <= DEF;
      r_match <= '0;
      r_sync <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tick <= w_tick;
      r_bit <= w_bit;
      r_sync <= w_commit;
      r_changed <= w_commit && w_take && r_sr != r_d;
      if (w_shift) r_sr <= WIDTH'({r_sr, bus.q});
      if (w_commit) begin
        r_d_raw <= r_sr;
        r_cand <= r_sr;
        r_match <= w_match;
        if (w_take) r_d <= r_sr;
      end
    end
  end
  // pl is forced high while reset is held so an aborted frame leaves the chain idle.
  assign bus.pl = !rst_n || r_state != LOAD;
  assign bus.cp = r_state == SHIFT && r_tick[0];
  assign bus.d_raw = r_d_raw;
  assign bus.d = r_d;
  assign bus.sync = r_sync;
  assign bus.changed = r_changed;
endmodule

// File: doc/shiftreg165_scan.md
Name: shiftreg165_scan

Overview:
- Parametrised serial-input scanner for a chain of 74HC165 parallel-in/serial-out registers (joystick, tape, extra keys).
- Generalises the fixed 8-bit, unfiltered scanner to any chain width and a configurable load-pulse length.
- Adds a consecutive-frame debounce filter, change detection and an output freeze.
- Sits between the board shift-register pins and consumers such as the joystick/gamepad logic and the ports block, clocked by clk28 and advanced on the ck7 enable strobe.

Parameters:
- WIDTH, 8: total number of bits in the chain (1..32); the first bit shifted in maps to d[WIDTH-1].
- DEFAULT_STATE, 1'b1: value of every bit of d, d_raw and the filter candidate after reset.
- FILTER, 2: number of consecutive identical frames required before d updates (1..4); 1 disables filtering.
- PL_CYCLES, 1: number of clk_en ticks that pl is held low in each frame (1..4).

Ports:
- clk28 input 1: system clock.
- rst_n input 1: asynchronous reset, active low.
- clk_en input 1: scan tick enable; all scanner state advances only on clk28 edges where clk_en=1.
- q input 1: serial data from the chain, sampled as-is.
- freeze input 1: when 1, d and changed are held and scanning continues.
- cp output 1: 165 clock pin.
- pl output 1: 165 parallel-load pin, active low.
- d_raw output WIDTH: last complete unfiltered frame.
- d output WIDTH: filtered frame.
- sync output 1: one-clk28 pulse when a frame commits.
- changed output 1: one-clk28 pulse when d takes a new value.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD, tick counter=0, bit counter=0.
  - pl=1, cp=0, sync=0, changed=0.
  - d, d_raw and candidate = {WIDTH{DEFAULT_STATE}}; match counter=0.
- FSM states LOAD, SHIFT and COMMIT; transitions occur only on ticks where clk_en=1.
- LOAD:
  - pl=0 and cp=0 for PL_CYCLES ticks.
  - Then pl returns to 1 and the FSM enters SHIFT with bit counter=0.
- SHIFT: each bit takes 2 ticks.
  - Tick A: the shift register takes {sr[WIDTH-2:0], q} and cp goes to 1.
  - Tick B: cp goes to 0 and the bit counter increments.
  - After tick B of bit WIDTH-1, the FSM enters COMMIT.
- COMMIT (1 tick):
  - d_raw receives the shift register and sync=1 for exactly that clk28 cycle.
  - The filter updates on the same edge, then the FSM returns to LOAD.
- Frame length is PL_CYCLES+2*WIDTH+1 ticks; with WIDTH=8 and PL_CYCLES=1 this is 18 ticks.
- Filter, evaluated at COMMIT with raw = the new frame:
  - raw != candidate: candidate becomes raw and the match counter becomes 0.
  - raw == candidate: the match counter increments, saturating at FILTER-1.
  - The effective match count is the new counter value; when it equals FILTER-1 and freeze=0, d receives candidate.
  - With FILTER=1, d receives raw at every COMMIT (when freeze=0), so d lags d_raw by 0 cycles.
- changed=1 for one clk28 cycle, on the same edge as sync, when d is updated to a value different from its previous value. It is never asserted while freeze=1.
- freeze=1 suppresses only the d update. The candidate and counter keep tracking, so d catches up on the first COMMIT after freeze drops if the match condition still holds.
- clk_en=0:
  - All registers hold, and pl and cp hold their levels.
  - sync and changed are pulses and deassert after their single cycle regardless of clk_en.
- Reset asserted mid-frame aborts immediately:
  - pl=1, cp=0, and a partial frame is never committed.
  - After release, the first committed frame is a full frame beginning with LOAD.
- Width rule: the bit counter is $clog2(WIDTH+1) bits and the tick counter is 2 bits. No combinational path exists from q to any output.

Test Plan:
- Reset, then clk_en every 4th clk28 with WIDTH=8 and q driven from a model chain holding 8'hA5.
  - pl is low for 1 tick and there are 8 cp rising edges per frame.
  - sync occurs every 18 ticks and d_raw=8'hA5.
- FILTER=2 with the chain changing 8'hFF->8'h3C.
  - d_raw=8'h3C after frame 1 while d stays 8'hFF.
  - d=8'h3C and changed pulses once after frame 2.
- FILTER=2 with a glitch of a single frame 8'hFE between 8'hFF frames: d stays 8'hFF and changed never asserts.
- freeze=1 during the change 8'hFF->8'h00.
  - d stays 8'hFF for 3 frames.
  - After freeze=0, the next COMMIT sets d=8'h00 with one changed pulse.
- rst_n pulsed low at bit 4 of SHIFT.
  - Outputs are at reset values at once and pl=1, cp=0.
  - The next sync comes exactly 18 ticks after release.
- WIDTH=16, PL_CYCLES=3, FILTER=1 with the chain at 16'h8001.
  - pl is low for 3 ticks and the frame is 36 ticks.
  - d=16'h8001 after the first COMMIT, and bit order is checked (the first shifted bit is d[15]).
